// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority M-mode interrupt controller; define IRQ_CTRL_LEVEL_EN for level-sensitive sources
module irq_ctrl #(
    parameter int unsigned NUM_IRQ    = 16,
    parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               stall_i,
    input  logic               gie_i,
    input  logic [NUM_IRQ-1:0] mie_i,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic               exception_i,
    input  logic               mret_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic [NUM_IRQ-1:0] irq_ret_o,
    output logic               busy_o
);
    localparam int unsigned IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
    typedef enum logic [1:0] {IDLE, TRAP, SERVICE, EXC} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, win;
    logic [NUM_IRQ-1:0] eligible, onehot;
    assign onehot = NUM_IRQ'(1) << idx_q;
`ifdef IRQ_CTRL_LEVEL_EN
    assign eligible = gie_i ? irq_req_i & mie_i : '0;
`else
    logic [NUM_IRQ-1:0] req_q, pending_q, clr;
    assign eligible = gie_i ? pending_q & mie_i : '0;
    assign clr = (state_q == TRAP && !stall_i) ? onehot : '0;
    // a new edge in the clearing cycle survives because the set term is ORed last
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q     <= '0;
            pending_q <= '0;
        end else begin
            req_q     <= irq_req_i;
            pending_q <= (pending_q & ~clr) | (irq_req_i & ~req_q);
        end
    end
`endif
    always_comb begin
        win = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--)
            if (eligible[i]) win = IW'(i);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        irq_ret_o = '0;
        case (state_q)
            IDLE: if (!stall_i) begin
                if (exception_i) state_d = EXC;
                else if (|eligible) begin
                    state_d = TRAP;
                    idx_d   = win;
                end
            end
            TRAP: if (!stall_i) state_d = SERVICE;
            SERVICE: if (mret_i && !stall_i) begin
                state_d   = IDLE;
                irq_ret_o = onehot;
            end
            default: if (mret_i && !stall_i) state_d = IDLE;
        endcase
    end
    assign irq_o       = state_q == TRAP;
    assign busy_o      = state_q != IDLE;
    assign irq_cause_o = CAUSE_BASE + 32'(idx_q);
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plus randomized checks of irq_ctrl (edge mode) against a behavioural model
module tb_irq_ctrl;
    localparam logic [31:0] BASE = 32'h8000_0010;
    logic        clk_i = 0, rst_ni = 0, stall_i = 0, gie_i = 0, exception_i = 0, mret_i = 0;
    logic [15:0] mie_i = 0, irq_req_i = 0;
    logic        irq_o, busy_o;
    logic [31:0] irq_cause_o;
    logic [15:0] irq_ret_o;
    int n_chk = 0, n_err = 0;

    irq_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .gie_i(gie_i), .mie_i(mie_i),
        .irq_req_i(irq_req_i), .exception_i(exception_i), .mret_i(mret_i), .irq_o(irq_o),
        .irq_cause_o(irq_cause_o), .irq_ret_o(irq_ret_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // model: context is one of "free", "trap", "handler", "exception"
    localparam int FREE = 0, IN_TRAP = 1, HANDLER = 2, IN_EXC = 3;
    int          ctx = FREE;
    int          src = 0;
    logic [15:0] pend = 0, prev = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [15:0] v);
        logic [15:0] iso;
        iso = v & (~v + 16'd1);
        return $clog2(iso);
    endfunction

    task automatic model_reset();
        ctx = FREE; src = 0; pend = 0; prev = 0;
    endtask

    task automatic step(input logic s, input logic g, input logic [15:0] m, input logic [15:0] r,
                        input logic e, input logic mr);
        logic [15:0] elig, clr;
        logic        ack;
        @(negedge clk_i);
        stall_i = s; gie_i = g; mie_i = m; irq_req_i = r; exception_i = e; mret_i = mr;
        #1;
        ack = ctx == HANDLER && mr && !s;
        check("irq", irq_o, ctx == IN_TRAP);
        check("busy", busy_o, ctx != FREE);
        check("cause", irq_cause_o, BASE + src);
        check("ret", irq_ret_o, ack ? 16'(1 << src) : 16'h0);
        @(posedge clk_i);
        elig = g ? pend & m : 16'h0;
        clr = 0;
        if (!s) begin
            if (ctx == FREE) begin
                if (e) ctx = IN_EXC;
                else if (elig != 0) begin ctx = IN_TRAP; src = lowest(elig); end
            end else if (ctx == IN_TRAP) begin
                clr = 16'(1 << src); ctx = HANDLER;
            end else if (mr) ctx = FREE;
        end
        pend = (pend & ~clr) | (r & ~prev);
        prev = r;
    endtask

    task automatic idle(input logic [15:0] m, input logic [15:0] r);
        step(0, 1, m, r, 0, 0);
    endtask

    initial begin
        irq_req_i = 16'hFFFF;
        repeat (3) begin
            @(negedge clk_i); #1;
            check("rst_irq", irq_o, 0);
            check("rst_cause", irq_cause_o, BASE);
            check("rst_ret", irq_ret_o, 0);
            check("rst_busy", busy_o, 0);
        end
        model_reset();
        @(negedge clk_i); rst_ni = 1;
        // drain the 16 sources latched at reset release, lowest first
        step(0, 0, 16'hFFFF, 16'hFFFF, 0, 0);
        for (int k = 0; k < 16; k++) begin
            idle(16'hFFFF, 16'hFFFF);
            #1; check("fill_cause", irq_cause_o, BASE + k);
            step(0, 1, 16'hFFFF, 16'hFFFF, 0, 0);
            step(0, 1, 16'hFFFF, 16'hFFFF, 0, 1);
        end
        idle(16'hFFFF, 0);
        // priority 3 over 5
        idle(16'hFFFF, 16'h0028);
        idle(16'hFFFF, 0);
        #1; check("prio_irq", irq_o, 1); check("prio_cause3", irq_cause_o, 32'h8000_0013);
        idle(16'hFFFF, 0);
        mret_i = 1; #1; check("prio_ret", irq_ret_o, 16'h0008);
        step(0, 1, 16'hFFFF, 0, 0, 1);
        idle(16'hFFFF, 0);
        #1; check("prio_cause5", irq_cause_o, 32'h8000_0015);
        idle(16'hFFFF, 0);
        step(0, 1, 16'hFFFF, 0, 0, 1);
        // masking retains pending
        idle(0, 16'h0004);
        repeat (10) idle(0, 0);
        #1; check("mask_irq", irq_o, 0);
        idle(16'h0004, 0);
        #1; check("unmask_irq", irq_o, 1); check("unmask_cause", irq_cause_o, 32'h8000_0012);
        idle(16'h0004, 0);
        step(0, 1, 16'h0004, 0, 0, 1);
        // stall holds TRAP and delays mret acknowledge
        idle(16'hFFFF, 16'h0200);
        idle(16'hFFFF, 0);
        repeat (4) step(1, 1, 16'hFFFF, 0, 0, 0);
        #1; check("stall_irq", irq_o, 1);
        idle(16'hFFFF, 0);
        repeat (2) step(1, 1, 16'hFFFF, 0, 0, 1);
        step(0, 1, 16'hFFFF, 0, 0, 1);
        // exception beats irq 0
        idle(16'hFFFF, 16'h0001);
        step(0, 1, 16'hFFFF, 0, 1, 0);
        #1; check("exc_irq", irq_o, 0); check("exc_busy", busy_o, 1);
        step(0, 1, 16'hFFFF, 0, 1, 0);
        step(0, 1, 16'hFFFF, 0, 0, 1);
        idle(16'hFFFF, 0);
        #1; check("exc_retrap", irq_cause_o, 32'h8000_0010);
        idle(16'hFFFF, 0);
        step(0, 1, 16'hFFFF, 0, 0, 1);
        // new edge on 7 while its trap is exiting keeps it pending
        idle(16'hFFFF, 16'h0080);
        idle(16'hFFFF, 0);
        idle(16'hFFFF, 16'h0080);
        step(0, 1, 16'hFFFF, 0, 0, 1);
        idle(16'hFFFF, 0);
        #1; check("setclr_irq", irq_o, 1); check("setclr_cause", irq_cause_o, 32'h8000_0017);
        idle(16'hFFFF, 0);
        step(0, 1, 16'hFFFF, 0, 0, 1);
        // async reset in the middle of a trap
        idle(16'hFFFF, 16'h0002);
        idle(16'hFFFF, 16'h0002);
        #2 rst_ni = 0;
        #1; check("arst_irq", irq_o, 0); check("arst_busy", busy_o, 0);
        check("arst_cause", irq_cause_o, BASE);
        model_reset();
        @(negedge clk_i); irq_req_i = 0;
        @(negedge clk_i); rst_ni = 1;
        for (int c = 0; c < 3000; c++) begin
            step(($urandom % 8) == 0, ($urandom % 8) != 0, 16'($urandom | $urandom),
                 16'($urandom & $urandom & $urandom), ($urandom % 32) == 0, ($urandom % 4) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
